// File: rtl/axi4_sram_slave_if.sv
// rtl/axi4_sram_slave_if.sv - AXI4 bus bundle between the data-bus master and the SRAM responder
//
// Ports (all five AXI4 channels, 32-bit data, 16-bit IDs):
//   AW: s_awvalid s_awready s_awaddr s_awid s_awlen s_awsize s_awburst
//   W : s_wvalid s_wready s_wdata s_wstrb s_wlast
//   B : s_bvalid s_bready s_bid s_bresp
//   AR: s_arvalid s_arready s_araddr s_arid s_arlen s_arsize s_arburst
//   R : s_rvalid s_rready s_rdata s_rid s_rresp s_rlast
// Modports: master (drives requests), slave (drives responses/readies).
interface axi4_sram_slave_if;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_awaddr;
  logic [15:0] s_awid;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;

  logic        s_wvalid;
  logic        s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast;

  logic        s_bvalid;
  logic        s_bready;
  logic [15:0] s_bid;
  logic [1:0]  s_bresp;

  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_araddr;
  logic [15:0] s_arid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;

  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] s_rdata;
  logic [15:0] s_rid;
  logic [1:0]  s_rresp;
  logic        s_rlast;

  modport slave (
    input  s_awvalid, s_awaddr, s_awid, s_awlen, s_awsize, s_awburst,
    output s_awready,
    input  s_wvalid, s_wdata, s_wstrb, s_wlast,
    output s_wready,
    output s_bvalid, s_bid, s_bresp,
    input  s_bready,
    input  s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst,
    output s_arready,
    output s_rvalid, s_rdata, s_rid, s_rresp, s_rlast,
    input  s_rready
  );

  modport master (
    output s_awvalid, s_awaddr, s_awid, s_awlen, s_awsize, s_awburst,
    input  s_awready,
    output s_wvalid, s_wdata, s_wstrb, s_wlast,
    input  s_wready,
    input  s_bvalid, s_bid, s_bresp,
    output s_bready,
    output s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst,
    input  s_arready,
    input  s_rvalid, s_rdata, s_rid, s_rresp, s_rlast,
    output s_rready
  );
endinterface

// File: rtl/axi4_sram_slave.sv
// rtl/axi4_sram_slave.sv - AXI4 responder backed by a single-port word-addressed SRAM
//
// Serves one transaction at a time (no interleaving); AW/AR arbitration is
// round-robin. Bursts FIXED/INCR/WRAP up to 256 beats.
//
// Ports:
//   clk  - clock, all logic on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - axi4_sram_slave_if.slave (AW, W, B, AR, R channels)
//
// Parameters: ADDR_BASE (byte address of word 0), MEM_WORDS (power of two),
//             INIT_FILE (hex image name; no file is read by this model).
//
// Optional feature macro: AXI4_SRAM_ERR_EN
//   defined   - per-beat range check (DECERR, read data 0, write dropped),
//               SLVERR on beat-count/s_wlast mismatch, worst code in s_bresp
//   undefined - addresses alias modulo MEM_WORDS, responses always OKAY
module axi4_sram_slave #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int          MEM_WORDS = 4096,
  parameter string       INIT_FILE = ""
) (
  input logic              clk,
  input logic              rst,
  axi4_sram_slave_if.slave bus
);

  localparam int         IDX_W  = $clog2(MEM_WORDS);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

  state_t state, state_nx;

  logic [31:0] mem [MEM_WORDS];

  // Burst context, shared by the write and read paths (only one is active).
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic        prefer_rd;   // 1: read wins a tie next time

  logic [15:0] bid_q;
  logic [1:0]  bresp_q;
  logic [1:0]  wacc_q;      // worst write code seen so far in this burst
  logic [15:0] rid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rlast_q;

  logic aw_ready, ar_ready, w_ready, b_valid, r_valid;
  logic w_fire, r_fire;

  logic [31:0]      seq_addr;
  logic [31:0]      rd_addr;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_ok;
  logic             wr_ok;
  logic [1:0]       w_code;

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - ADDR_BASE) >> 2);
  endfunction

  // Address of the beat following 'a'. WRAP only applies for 2/4/8/16 beats;
  // other lengths fall back to INCR, as does the reserved burst type.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step;
    logic [31:0] cont;
    logic        wrap_ok;
    logic [31:0] nxt;
    step    = 32'd1 << size;
    cont    = ({24'd0, len} + 32'd1) * step;
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    nxt     = a + step;
    case (burst)
      2'b00:   nxt = a;
      2'b10:   if (wrap_ok) nxt = (a & ~(cont - 32'd1)) | ((a + step) & (cont - 32'd1));
      default: nxt = a + step;
    endcase
    return nxt;
  endfunction

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

`ifdef AXI4_SRAM_ERR_EN
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

  function automatic logic in_range(input logic [31:0] a);
    return (a >= ADDR_BASE) && ({1'b0, a - ADDR_BASE} < MEM_BYTES);
  endfunction
`endif

  // The first read beat is fetched on the AR handshake straight from s_araddr
  // so s_rvalid can rise the following cycle; later beats fetch the next
  // sequenced address as the current beat is consumed.
  always_comb begin
    seq_addr = next_addr(addr_q, len_q, size_q, burst_q);
    rd_addr  = (state == IDLE) ? bus.s_araddr : seq_addr;
    rd_idx   = word_idx(rd_addr);
    wr_idx   = word_idx(addr_q);
`ifdef AXI4_SRAM_ERR_EN
    rd_ok  = in_range(rd_addr);
    wr_ok  = in_range(addr_q);
    if (!wr_ok)
      w_code = DECERR;
    else if (bus.s_wlast != (beat_q == len_q))
      w_code = SLVERR;
    else
      w_code = OKAY;
`else
    rd_ok  = 1'b1;
    wr_ok  = 1'b1;
    w_code = OKAY;
`endif
  end

`ifndef AXI4_SRAM_ERR_EN
  // Completion is purely by beat count here, so s_wlast carries no meaning.
  logic unused_wlast;
  assign unused_wlast = bus.s_wlast;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    aw_ready = 1'b0;
    ar_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    r_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.s_awvalid && (!bus.s_arvalid || !prefer_rd)) begin
          aw_ready = 1'b1;
          state_nx = WDATA;
        end else if (bus.s_arvalid) begin
          ar_ready = 1'b1;
          state_nx = RDATA;
        end
      end
      WDATA: begin
        w_ready = 1'b1;
        if (bus.s_wvalid && (beat_q == len_q)) state_nx = WRESP;
      end
      WRESP: begin
        b_valid = 1'b1;
        if (bus.s_bready) state_nx = IDLE;
      end
      RDATA: begin
        r_valid = 1'b1;
        if (bus.s_rready && rlast_q) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign w_fire = w_ready && bus.s_wvalid;
  assign r_fire = r_valid && bus.s_rready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      prefer_rd <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= OKAY;
      wacc_q    <= OKAY;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      rlast_q   <= 1'b0;
    end else begin
      if (aw_ready) begin
        addr_q    <= bus.s_awaddr;
        len_q     <= bus.s_awlen;
        size_q    <= bus.s_awsize;
        burst_q   <= bus.s_awburst;
        beat_q    <= '0;
        bid_q     <= bus.s_awid;
        wacc_q    <= OKAY;
        prefer_rd <= 1'b1;
      end
      if (ar_ready) begin
        addr_q    <= bus.s_araddr;
        len_q     <= bus.s_arlen;
        size_q    <= bus.s_arsize;
        burst_q   <= bus.s_arburst;
        beat_q    <= '0;
        rid_q     <= bus.s_arid;
        rdata_q   <= rd_ok ? mem[rd_idx] : 32'd0;
        rresp_q   <= rd_ok ? OKAY : DECERR;
        rlast_q   <= (bus.s_arlen == 8'd0);
        prefer_rd <= 1'b0;
      end
      if (w_fire) begin
        addr_q <= seq_addr;
        beat_q <= beat_q + 8'd1;
        wacc_q <= worst(wacc_q, w_code);
        if (beat_q == len_q) bresp_q <= worst(wacc_q, w_code);
      end
      // Data registers only advance on a handshake, so a stalled beat holds.
      if (r_fire && !rlast_q) begin
        addr_q  <= seq_addr;
        beat_q  <= beat_q + 8'd1;
        rdata_q <= rd_ok ? mem[rd_idx] : 32'd0;
        rresp_q <= rd_ok ? OKAY : DECERR;
        rlast_q <= ((beat_q + 8'd1) == len_q);
      end
    end
  end

  // SRAM array: never reset, so a reset leaves its contents intact.
  always_ff @(posedge clk) begin
    if (w_fire && wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.s_wstrb[i]) mem[wr_idx][8*i +: 8] <= bus.s_wdata[8*i +: 8];
      end
    end
  end

  assign bus.s_awready = aw_ready;
  assign bus.s_arready = ar_ready;
  assign bus.s_wready  = w_ready;
  assign bus.s_bvalid  = b_valid;
  assign bus.s_bid     = bid_q;
  assign bus.s_bresp   = bresp_q;
  assign bus.s_rvalid  = r_valid;
  assign bus.s_rdata   = rdata_q;
  assign bus.s_rid     = rid_q;
  assign bus.s_rresp   = rresp_q;
  assign bus.s_rlast   = rlast_q;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// tb/tb_axi4_sram_slave.sv - self-checking bench for axi4_sram_slave with a byte-level memory model
module tb_axi4_sram_slave;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WORDS = 4096;

  typedef logic [31:0] wq_t [$];
  typedef logic [3:0]  sq_t [$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi4_sram_slave_if bus();

  axi4_sram_slave #(.ADDR_BASE(BASE), .MEM_WORDS(WORDS), .INIT_FILE("")) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] model [int];

  // Reference model: word index, beat address list and byte-lane writes.
  function automatic int widx(input logic [31:0] a);
    logic [31:0] w;
    w = ((a - BASE) >> 2) % WORDS;
    return int'(w);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                            input int size, input int burst, input int i);
    logic [31:0] step, total, base;
    step = 32'd1 << size;
    if (burst == 0) return start;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      total = 32'(len + 1) * step;
      base  = start - (start % total);
      return base + ((start - base + 32'(i) * step) % total);
    end
    return start + 32'(i) * step;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int w;
    logic [31:0] v;
    w = widx(a);
    v = model.exists(w) ? model[w] : 32'hx;
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    model[w] = v;
  endfunction

  function automatic wq_t model_read(input logic [31:0] a, input int len, input int size, input int burst);
    wq_t q;
    int w;
    for (int i = 0; i <= len; i++) begin
      w = widx(beat_addr(a, len, size, burst, i));
      q.push_back(model.exists(w) ? model[w] : 32'hx);
    end
    return q;
  endfunction

  task automatic do_write(input string name, input logic [31:0] a, input logic [15:0] id,
                          input int len, input int size, input int burst, input wq_t d,
                          input sq_t s, input int wlast_beat, input logic [1:0] bresp_exp);
    int n;
    bus.s_awaddr = a; bus.s_awid = id; bus.s_awlen = 8'(len);
    bus.s_awsize = 3'(size); bus.s_awburst = 2'(burst); bus.s_awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.s_awready && n < 50) begin @(negedge clk); n++; end
    if (bus.s_awready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL %s aw_handshake: awready=%b after %0d cycles, required 1", name, bus.s_awready, n);
    end
    @(posedge clk); #1 bus.s_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bus.s_wdata = d[i]; bus.s_wstrb = s[i]; bus.s_wlast = (i == wlast_beat); bus.s_wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.s_wready && n < 50) begin @(negedge clk); n++; end
      if (bus.s_wready !== 1'b1) begin
        tests++; fails++;
        $display("FAIL %s w_beat%0d: wready=%b, required 1", name, i, bus.s_wready);
      end
      @(posedge clk); #1;
      model_write(beat_addr(a, len, size, burst, i), d[i], s[i]);
    end
    bus.s_wvalid = 1'b0; bus.s_wlast = 1'b0; bus.s_bready = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.s_bvalid !== 1'b1 || bus.s_bid !== id || bus.s_bresp !== bresp_exp) begin
      fails++;
      $display("FAIL %s b_response: bvalid=%b bid=%h bresp=%b, required bvalid=1 bid=%h bresp=%b",
               name, bus.s_bvalid, bus.s_bid, bus.s_bresp, id, bresp_exp);
    end
    @(posedge clk); #1 bus.s_bready = 1'b0;
  endtask

  // mode 0: rready always 1, 1: toggles 1/0, 2: random
  task automatic do_read(input string name, input logic [31:0] a, input logic [15:0] id,
                         input int len, input int size, input int burst, input int mode,
                         input wq_t exp, input logic [1:0] rresp_exp);
    int n, beat, cyc;
    logic stalled;
    logic [31:0] hold_d;
    logic hold_l;
    bus.s_araddr = a; bus.s_arid = id; bus.s_arlen = 8'(len);
    bus.s_arsize = 3'(size); bus.s_arburst = 2'(burst); bus.s_arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.s_arready && n < 50) begin @(negedge clk); n++; end
    if (bus.s_arready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL %s ar_handshake: arready=%b after %0d cycles, required 1", name, bus.s_arready, n);
    end
    @(posedge clk); #1 bus.s_arvalid = 1'b0;
    beat = 0; cyc = 0; stalled = 1'b0; hold_d = '0; hold_l = 1'b0;
    while (beat <= len && cyc < 2000) begin
      bus.s_rready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (cyc == 0) begin
        tests++;
        if (bus.s_rvalid !== 1'b1) begin
          fails++;
          $display("FAIL %s first_beat_latency: rvalid=%b one cycle after AR, required 1", name, bus.s_rvalid);
        end
      end
      if (bus.s_rvalid === 1'b1) begin
        if (stalled) begin
          tests++;
          if (bus.s_rdata !== hold_d || bus.s_rlast !== hold_l) begin
            fails++;
            $display("FAIL %s stall_hold beat%0d: rdata=%h rlast=%b, required rdata=%h rlast=%b",
                     name, beat, bus.s_rdata, bus.s_rlast, hold_d, hold_l);
          end
        end
        if (bus.s_rready) begin
          tests++;
          if (bus.s_rdata !== exp[beat] || bus.s_rid !== id || bus.s_rresp !== rresp_exp ||
              bus.s_rlast !== (beat == len)) begin
            fails++;
            $display("FAIL %s r_beat%0d: rdata=%h rid=%h rresp=%b rlast=%b, required rdata=%h rid=%h rresp=%b rlast=%b",
                     name, beat, bus.s_rdata, bus.s_rid, bus.s_rresp, bus.s_rlast,
                     exp[beat], id, rresp_exp, (beat == len));
          end
          beat++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hold_d = bus.s_rdata;
          hold_l = bus.s_rlast;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.s_rready = 1'b0;
    tests++;
    if (beat <= len) begin
      fails++;
      $display("FAIL %s r_timeout: %0d beats received, required %0d", name, beat, len + 1);
    end
    @(negedge clk);
    tests++;
    if (bus.s_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL %s r_done: rvalid=%b after last beat, required 0", name, bus.s_rvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.s_awvalid = 0; bus.s_awaddr = 0; bus.s_awid = 0; bus.s_awlen = 0; bus.s_awsize = 0; bus.s_awburst = 0;
    bus.s_wvalid = 0; bus.s_wdata = 0; bus.s_wstrb = 0; bus.s_wlast = 0; bus.s_bready = 0;
    bus.s_arvalid = 0; bus.s_araddr = 0; bus.s_arid = 0; bus.s_arlen = 0; bus.s_arsize = 0; bus.s_arburst = 0;
    bus.s_rready = 0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.s_awready, bus.s_arready, bus.s_wready, bus.s_bvalid, bus.s_rvalid} !== 5'b0) begin
      fails++;
      $display("FAIL reset_handshakes: aw/ar/w ready, bvalid, rvalid=%b, required 00000",
               {bus.s_awready, bus.s_arready, bus.s_wready, bus.s_bvalid, bus.s_rvalid});
    end
    tests++;
    if (bus.s_bid !== 16'd0 || bus.s_bresp !== 2'd0 || bus.s_rid !== 16'd0 ||
        bus.s_rdata !== 32'd0 || bus.s_rresp !== 2'd0 || bus.s_rlast !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: bid=%h bresp=%b rid=%h rdata=%h rresp=%b rlast=%b, required all 0",
               bus.s_bid, bus.s_bresp, bus.s_rid, bus.s_rdata, bus.s_rresp, bus.s_rlast);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single;
    do_write("single_w", 32'h8000_0010, 16'h0012, 0, 2, 1, '{32'hDEADBEEF}, '{4'hF}, 0, 2'b00);
    do_read("single_r", 32'h8000_0010, 16'h0012, 0, 2, 1, 0, '{32'hDEADBEEF}, 2'b00);
  endtask

  task automatic test_incr_backpressure;
    do_write("incr_w", BASE, 16'h0003, 3, 2, 1, '{1, 2, 3, 4}, '{4'hF, 4'hF, 4'hF, 4'hF}, 3, 2'b00);
    do_read("incr_r", BASE, 16'h00A1, 3, 2, 1, 1, '{1, 2, 3, 4}, 2'b00);
  endtask

  task automatic test_wrap;
    do_read("wrap_r", 32'h8000_0008, 16'h00B2, 3, 2, 2, 0, '{3, 4, 1, 2}, 2'b00);
  endtask

  task automatic test_partial_strobe;
    do_write("strobe_w0", 32'h8000_0040, 16'h0040, 0, 2, 1, '{32'h11223344}, '{4'hF}, 0, 2'b00);
    do_write("strobe_w1", 32'h8000_0040, 16'h0041, 0, 2, 1, '{32'hAABBCCDD}, '{4'h5}, 0, 2'b00);
    do_read("strobe_r", 32'h8000_0040, 16'h0042, 0, 2, 1, 0, '{32'h11BB33DD}, 2'b00);
  endtask

  // Read targets the word the competing write updates: seeing the new data
  // proves the write was served first.
  task automatic test_arbitration;
    logic [31:0] a, d;
    for (int k = 0; k < 2; k++) begin
      a = 32'h8000_0200 + 32'(k * 4);
      d = $urandom;
      bus.s_awaddr = a; bus.s_awid = 16'(16'h0A00 + k); bus.s_awlen = 0; bus.s_awsize = 2; bus.s_awburst = 1;
      bus.s_araddr = a; bus.s_arid = 16'(16'h0B00 + k); bus.s_arlen = 0; bus.s_arsize = 2; bus.s_arburst = 1;
      bus.s_awvalid = 1'b1; bus.s_arvalid = 1'b1;
      @(negedge clk);
      tests++;
      if (bus.s_awready !== 1'b1 || bus.s_arready !== 1'b0) begin
        fails++;
        $display("FAIL arb_tie%0d: awready=%b arready=%b, required 1 0", k, bus.s_awready, bus.s_arready);
      end
      @(posedge clk); #1 bus.s_awvalid = 1'b0;
      bus.s_wdata = d; bus.s_wstrb = 4'hF; bus.s_wlast = 1'b1; bus.s_wvalid = 1'b1;
      @(posedge clk); #1 bus.s_wvalid = 1'b0; bus.s_wlast = 1'b0; bus.s_bready = 1'b1;
      model_write(a, d, 4'hF);
      @(negedge clk);
      tests++;
      if (bus.s_bvalid !== 1'b1 || bus.s_bid !== 16'(16'h0A00 + k)) begin
        fails++;
        $display("FAIL arb_b%0d: bvalid=%b bid=%h, required 1 %h", k, bus.s_bvalid, bus.s_bid, 16'(16'h0A00 + k));
      end
      @(posedge clk); #1 bus.s_bready = 1'b0; bus.s_rready = 1'b1;
      @(negedge clk);
      tests++;
      if (bus.s_arready !== 1'b1) begin
        fails++;
        $display("FAIL arb_ar%0d: arready=%b after write, required 1", k, bus.s_arready);
      end
      @(posedge clk); #1 bus.s_arvalid = 1'b0;
      @(negedge clk);
      tests++;
      if (bus.s_rvalid !== 1'b1 || bus.s_rdata !== d || bus.s_rid !== 16'(16'h0B00 + k) || bus.s_rlast !== 1'b1) begin
        fails++;
        $display("FAIL arb_r%0d: rvalid=%b rdata=%h rid=%h rlast=%b, required 1 %h %h 1",
                 k, bus.s_rvalid, bus.s_rdata, bus.s_rid, bus.s_rlast, d, 16'(16'h0B00 + k));
      end
      @(posedge clk); #1 bus.s_rready = 1'b0;
    end
  endtask

  task automatic test_reset_mid_burst;
    wq_t d;
    sq_t s;
    for (int i = 0; i < 8; i++) begin d.push_back($urandom); s.push_back(4'hF); end
    do_write("rst_fill", 32'h8000_0300, 16'h0300, 7, 2, 1, d, s, 7, 2'b00);
    bus.s_araddr = 32'h8000_0300; bus.s_arid = 16'h0301; bus.s_arlen = 7;
    bus.s_arsize = 2; bus.s_arburst = 1; bus.s_arvalid = 1'b1;
    @(posedge clk); #1 bus.s_arvalid = 1'b0; bus.s_rready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (bus.s_rvalid !== 1'b0 || bus.s_rdata !== 32'd0) begin
      fails++;
      $display("FAIL rst_mid_burst: rvalid=%b rdata=%h during reset, required 0 0", bus.s_rvalid, bus.s_rdata);
    end
    bus.s_rready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    do_read("rst_after", 32'h8000_0300, 16'h0302, 7, 2, 1, 2, d, 2'b00);
  endtask

  task automatic test_fixed_long;
    wq_t d;
    sq_t s;
    for (int i = 0; i < 256; i++) begin d.push_back($urandom); s.push_back(4'hF); end
    do_write("fixed_w", 32'h8000_0190, 16'h0190, 255, 2, 0, d, s, 255, 2'b00);
    do_read("fixed_r", 32'h8000_0190, 16'h0191, 3, 2, 0, 0, '{d[255], d[255], d[255], d[255]}, 2'b00);
  endtask

  task automatic test_random;
    wq_t d;
    sq_t s;
    int burst, size, len, word, rw;
    logic [31:0] a, step;
    for (int i = 0; i < 64; i++) begin d.push_back($urandom); s.push_back(4'hF); end
    do_write("rand_fill", BASE, 16'h0000, 63, 2, 1, d, s, 63, 2'b00);
    for (int t = 0; t < 40; t++) begin
      burst = $urandom_range(0, 3);
      size  = $urandom_range(0, 2);
      len   = (burst == 2) ? (2 ** $urandom_range(1, 4)) - 1 : $urandom_range(0, 15);
      word  = $urandom_range(0, 31);
      step  = 32'd1 << size;
      a     = BASE + 32'(word * 4) + (32'($urandom_range(0, 3)) & ~(step - 32'd1));
      rw    = $urandom_range(0, 1);
      if (rw == 0) begin
        d.delete(); s.delete();
        for (int i = 0; i <= len; i++) begin d.push_back($urandom); s.push_back(4'($urandom)); end
        do_write($sformatf("rand_w%0d", t), a, 16'($urandom), len, size, burst, d, s, len, 2'b00);
      end else begin
        do_read($sformatf("rand_r%0d", t), a, 16'($urandom), len, size, burst, 2,
                model_read(a, len, size, burst), 2'b00);
      end
    end
  endtask

`ifndef AXI4_SRAM_ERR_EN
  task automatic test_alias;
    do_write("alias_w", BASE + 32'(WORDS * 4) + 32'h8, 16'h0777, 0, 2, 1, '{32'hC0FFEE01}, '{4'hF}, 0, 2'b00);
    do_read("alias_r", BASE + 32'h8, 16'h0778, 0, 2, 1, 0, '{32'hC0FFEE01}, 2'b00);
  endtask
`else
  task automatic test_errors;
    do_read("err_decerr", 32'h7FFF_FFFC, 16'h0E01, 0, 2, 1, 0, '{32'd0}, 2'b11);
    do_write("err_wlast", BASE + 32'h800, 16'h0E02, 1, 2, 1, '{32'h1, 32'h2}, '{4'hF, 4'hF}, 0, 2'b10);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_incr_backpressure();
    test_wrap();
    test_partial_strobe();
    test_arbitration();
    test_reset_mid_burst();
    test_fixed_long();
`ifndef AXI4_SRAM_ERR_EN
    test_alias();
`else
    test_errors();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
